muldiv_seq: RTL and testbench

Iterative unsigned multiply/divide sequencer that supplies the RV32M MUL, MULHU, DIVU and REMU results to the execute stage. It instantiates one 32-bit `ALU` and drives it for 32 cycles per operation, using only the ADD (ctrl 4'b0000) and SUB (ctrl 4'b0001) encodings. Carry and compare logic is implemented locally. The pipeline stalls on `busy` and captures `result` on `done`.

---
 rtl/muldiv_seq.sv | 168 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative unsigned multiply/divide sequencer (MUL, MULHU, DIVU, REMU).
// A single shared 32-bit ALU performs one add (multiply) or subtract (divide)
// per RUN cycle; 32 cycles produce a full result.

// Small general-purpose ALU; this sequencer only exercises ADD and SUB.
module ALU (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  ctrl_i,
  output logic [31:0] y_o
);

  // Combinational operation select.
  always_comb begin
    y_o = 32'd0;
    case (ctrl_i)
      4'b0000: y_o = a_i + b_i;
      4'b0001: y_o = a_i - b_i;
      4'b0010: y_o = a_i & b_i;
      4'b0011: y_o = a_i | b_i;
      4'b0100: y_o = a_i ^ b_i;
      default: y_o = 32'd0;
    endcase
  end

endmodule

module muldiv_seq #(
  parameter bit EARLY_DIV0 = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  // hi_q doubles as the remainder and lo_q as the quotient during a divide.
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] b_q, b_d;
  logic [31:0] result_q, result_d;

  logic        isDiv;
  logic [31:0] divT;
  logic        divOut;
  logic        divGe;
  logic        mulCarry;
  logic [31:0] aluA;
  logic [3:0]  aluCtrl;
  logic [31:0] aluY;
  logic [31:0] stepHi;
  logic [31:0] stepLo;
  logic        reqDiv0;

  ALU uAlu (
    .a_i    (aluA),
    .b_i    (b_q),
    .ctrl_i (aluCtrl),
    .y_o    (aluY)
  );

  // One iteration of shift-add multiply or restoring divide, from the registered datapath.
  always_comb begin
    isDiv    = op_q[1];
    divT     = {hi_q[30:0], lo_q[31]};
    divOut   = hi_q[31];
    aluA     = isDiv ? divT : hi_q;
    aluCtrl  = isDiv ? ALU_SUB : ALU_ADD;
    mulCarry = (aluY < hi_q);
    divGe    = divOut || (divT >= b_q);
    stepHi   = hi_q;
    stepLo   = lo_q;
    if (isDiv) begin
      stepHi = divGe ? aluY : divT;
      stepLo = {lo_q[30:0], divGe};
    end else if (lo_q[0]) begin
      stepHi = {mulCarry, aluY[31:1]};
      stepLo = {aluY[0], lo_q[31:1]};
    end else begin
      stepHi = {1'b0, hi_q[31:1]};
      stepLo = {hi_q[0], lo_q[31:1]};
    end
  end

  // Next-state logic: acceptance in IDLE/DONE, iteration in RUN, result capture on entry to DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    result_d = result_q;
    reqDiv0  = op[1] && (b == 32'd0);
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          op_d  = op;
          b_d   = b;
          cnt_d = 5'd0;
          hi_d  = 32'd0;
          lo_d  = a;
          if (EARLY_DIV0 && reqDiv0) begin
            state_d  = DONE;
            result_d = op[0] ? a : 32'hFFFF_FFFF;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        hi_d  = stepHi;
        lo_d  = stepLo;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = DONE;
          result_d = op_q[0] ? stepHi : stepLo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 2'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      b_q      <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: drives two sequencers (early and late divide-by-zero) with the same
// stimulus and compares both against a cycle-count/arithmetic reference model.
module tb_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busyE, doneE, busyL, doneL;
  logic [31:0] resultE, resultL;

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;

  // Reference model state per instance: 0 = early div0, 1 = full iteration.
  int          left  [2];
  logic        mDone [2];
  logic [31:0] mRes  [2];
  logic [31:0] mPend [2];

  muldiv_seq #(.EARLY_DIV0(1'b1)) dutE (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busyE), .done(doneE), .result(resultE)
  );

  muldiv_seq #(.EARLY_DIV0(1'b0)) dutL (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busyL), .done(doneL), .result(resultL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected arithmetic result of one operation.
  function automatic logic [31:0] refOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    p = {32'd0, x} * {32'd0, y};
    case (o)
      2'd0:    refOp = p[31:0];
      2'd1:    refOp = p[63:32];
      2'd2:    refOp = (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      default: refOp = (y == 32'd0) ? x : x % y;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation occupies 32 busy cycles, then one done cycle.
  initial begin
    for (int i = 0; i < 2; i++) begin
      left[i] = 0; mDone[i] = 1'b0; mRes[i] = 32'd0; mPend[i] = 32'd0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        left[i]  = 0;
        mDone[i] = 1'b0;
        mRes[i]  = 32'd0;
      end else begin
        mDone[i] = 1'b0;
        if (left[i] > 0) begin
          left[i] = left[i] - 1;
          if (left[i] == 0) begin
            mDone[i] = 1'b1;
            mRes[i]  = mPend[i];
          end
        end else if (start) begin
          if (i == 0 && op[1] && b == 32'd0) begin
            mDone[i] = 1'b1;
            mRes[i]  = refOp(op, a, b);
          end else begin
            left[i]  = 32;
            mPend[i] = refOp(op, a, b);
          end
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busyE",   {31'd0, busyE}, {31'd0, (left[0] > 0)});
      checkOutput("doneE",   {31'd0, doneE}, {31'd0, mDone[0]});
      checkOutput("resultE", resultE, mRes[0]);
      checkOutput("busyL",   {31'd0, busyL}, {31'd0, (left[1] > 0)});
      checkOutput("doneL",   {31'd0, doneL}, {31'd0, mDone[1]});
      checkOutput("resultL", resultL, mRes[1]);
    end
  end

  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Scans up to cycle 40 after acceptance; records the cycle of the first done per instance.
  task automatic waitDone(input int fromK, output int latE, output int latL);
    latE = 0; latL = 0;
    for (int k = fromK; k <= 40; k++) begin
      if (doneE && latE == 0) latE = k;
      if (doneL && latL == 0) latL = k;
      if (k < 40) @(negedge clk);
    end
  endtask

  task automatic runOp(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] expRes, input int expLatE, input int expLatL);
    int latE, latL;
    applyStimulus(o, x, y);
    waitDone(1, latE, latL);
    checkOutput({name, " resultE"}, resultE, expRes);
    checkOutput({name, " resultL"}, resultL, expRes);
    checkOutput({name, " model"},   mRes[0], expRes);
    checkOutput({name, " latE"},    latE, expLatE);
    checkOutput({name, " latL"},    latL, expLatL);
  endtask

  initial begin
    int latE, latL;
    int k;
    rst = 1'b1; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("reset busy",   {31'd0, busyE}, 32'd0);
    checkOutput("reset done",   {31'd0, doneE}, 32'd0);
    checkOutput("reset result", resultE, 32'd0);
    rst = 1'b0;

    runOp("mul7x6",    2'd0, 32'd7, 32'd6, 32'h0000_002A, 33, 33);
    runOp("mulhu7x6",  2'd1, 32'd7, 32'd6, 32'h0000_0000, 33, 33);
    runOp("mulhuMax",  2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 33);
    runOp("mulMax",    2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 33);
    runOp("divu100_7", 2'd2, 32'd100, 32'd7, 32'h0000_000E, 33, 33);
    runOp("remu100_7", 2'd3, 32'd100, 32'd7, 32'h0000_0002, 33, 33);
    runOp("divuTop",   2'd2, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 33, 33);
    runOp("remuTop",   2'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 33, 33);
    runOp("divu0",     2'd2, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, 33);
    runOp("remu0",     2'd3, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, 33);

    // start with a different op during RUN must be ignored
    applyStimulus(2'd0, 32'd9, 32'd11);
    repeat (4) @(negedge clk);
    op = 2'd2; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(6, latE, latL);
    checkOutput("midrun result", resultE, 32'd99);
    checkOutput("midrun lat",    latE, 33);

    // start in the DONE cycle is accepted, next done 33 cycles later
    applyStimulus(2'd0, 32'd7, 32'd6);
    k = 1;
    while (!doneE && k < 40) begin
      @(negedge clk);
      k++;
    end
    checkOutput("b2b first done", {31'd0, doneE}, 32'd1);
    op = 2'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(1, latE, latL);
    checkOutput("b2b lat",    latE, 33);
    checkOutput("b2b result", resultE, 32'hFFFF_FFFE);

    // reset in the middle of RUN aborts the operation
    applyStimulus(2'd0, 32'd1000, 32'd1000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort busy",   {31'd0, busyE}, 32'd0);
    checkOutput("abort done",   {31'd0, doneE}, 32'd0);
    checkOutput("abort result", resultE, 32'd0);
    waitDone(1, latE, latL);
    checkOutput("abort no done", latE, 0);
    runOp("mul3x5", 2'd0, 32'd3, 32'd5, 32'd15, 33, 33);

    // reset and start together: reset wins
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = 2'd0; a = 32'd5; b = 32'd5;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checkOutput("rst+start busy", {31'd0, busyE}, 32'd0);

    // randomized traffic, including long stretches of start held high
    for (int it = 0; it < 150; it++) begin
      int holdCycles;
      holdCycles = $urandom_range(1, 80);
      for (int c = 0; c < holdCycles; c++) begin
        @(negedge clk);
        op = 2'($urandom_range(0, 3));
        a  = $urandom;
        case ($urandom_range(0, 7))
          0, 1:    b = 32'd0;
          2:       b = 32'($urandom_range(1, 15));
          3:       b = 32'h8000_0000 | $urandom;
          default: b = $urandom;
        endcase
        start = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      start = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
